// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state encoding for the arbiter and its requester agents
package arb_pkg;
    localparam int REQ_N = 4;
    localparam int WAIT_CNT_W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        XFER = ST_XFER,
        GAP  = ST_GAP
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at MAX
module sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en && cnt != W'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/arb_requester.sv
// arb_requester: requests one arbiter slot per job and issues len+1 beats while granted
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W    = 4,
    parameter int WAIT_MAX = 8,
    parameter int GAP_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             done,
    output logic             starve
);
    localparam int GAP_W = $clog2(GAP_CYC + 2);
    state_t state, state_n;
    logic [LEN_W-1:0] len_q, cnt, idx_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic accept, waiting, last_beat, gap_end;
    assign accept     = job_ready && job_valid;
    assign waiting    = state == WAIT && !gnt;
    assign job_ready  = state == IDLE;
    assign beat_valid = (state == WAIT || state == XFER) && gnt;
    assign last_beat  = beat_valid && cnt == len_q;
    assign gap_end    = int'(gap_cnt) >= GAP_CYC - 1;
    // cnt points at the next beat; idx_q keeps the last issued index between beats
    assign beat_idx   = beat_valid ? cnt : idx_q;
    sat_counter #(.W(WAIT_CNT_W), .MAX(WAIT_MAX)) u_wait (
        .clk(clk),
        .rst(rst),
        .clr(accept),
        .en (waiting),
        .cnt(wait_cnt)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (job_valid) state_n = WAIT;
            WAIT, XFER: if (last_beat) state_n = GAP; else if (beat_valid) state_n = XFER;
            GAP:        if (gap_end) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            idx_q   <= '0;
            gap_cnt <= '0;
            req     <= 1'b0;
            done    <= 1'b0;
            starve  <= 1'b0;
        end else begin
            state   <= state_n;
            req     <= state_n == WAIT || state_n == XFER;
            done    <= state_n == GAP && state != GAP;
            starve  <= waiting && wait_cnt == WAIT_CNT_W'(WAIT_MAX - 1);
            gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
            if (accept) begin
                len_q <= job_len;
                cnt   <= '0;
            end else if (beat_valid) begin
                idx_q <= cnt;
                if (cnt != len_q) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: scoreboard bench for the requester agent, standalone and on a 4-way arbiter
module tb_arb_requester;
    import arb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // standalone instance, GAP_CYC=1
    logic job_valid = 1'b0, gnt = 1'b0;
    logic [3:0] job_len = '0;
    logic job_ready, req, beat_valid, done, starve;
    logic [3:0] beat_idx;
    int q[$];
    int done_cnt = 0;
    arb_requester #(.LEN_W(4), .WAIT_MAX(8), .GAP_CYC(1)) u0 (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_len(job_len),
        .job_ready(job_ready), .req(req), .gnt(gnt), .beat_valid(beat_valid),
        .beat_idx(beat_idx), .done(done), .starve(starve)
    );
    task automatic push_job(input int len);
        for (int i = 0; i <= len; i++) q.push_back(i);
    endtask
    always @(negedge clk) begin
        if (beat_valid) begin
            if (q.size() == 0) chk("beat_unexpected", beat_idx, -1);
            else chk("beat_idx", beat_idx, q.pop_front());
        end
        if (done) done_cnt++;
    end
    // standalone instance, GAP_CYC=0
    logic g_jv = 1'b0, g_gnt = 1'b0;
    logic [3:0] g_len = '0;
    logic g_rdy, g_req, g_bv, g_done, g_starve;
    logic [3:0] g_idx;
    arb_requester #(.LEN_W(4), .WAIT_MAX(8), .GAP_CYC(0)) u_g0 (
        .clk(clk), .rst(rst), .job_valid(g_jv), .job_len(g_len),
        .job_ready(g_rdy), .req(g_req), .gnt(g_gnt), .beat_valid(g_bv),
        .beat_idx(g_idx), .done(g_done), .starve(g_starve)
    );
    // four instances behind a fixed-priority arbiter, bit 0 highest
    logic [REQ_N-1:0] a_jv = '0;
    logic [REQ_N-1:0] a_rdy, a_req, a_gnt, a_bv, a_done, a_starve;
    logic [3:0] a_len [REQ_N];
    logic [3:0] a_idx [REQ_N];
    int aq [REQ_N][$];
    int a_beats [REQ_N] = '{default: 0};
    int a_starves [REQ_N] = '{default: 0};
    int exp_beats [REQ_N] = '{default: 0};
    int done_a = 0;
    assign a_gnt = a_req & (~a_req + 1'b1);
    for (genvar i = 0; i < REQ_N; i++) begin : g_arb
        arb_requester #(.LEN_W(4), .WAIT_MAX(8), .GAP_CYC(1)) u (
            .clk(clk), .rst(rst), .job_valid(a_jv[i]), .job_len(a_len[i]),
            .job_ready(a_rdy[i]), .req(a_req[i]), .gnt(a_gnt[i]), .beat_valid(a_bv[i]),
            .beat_idx(a_idx[i]), .done(a_done[i]), .starve(a_starve[i])
        );
    end
    task automatic arb_job(input int i, input int len);
        a_len[i] = 4'(len);
        exp_beats[i] += len + 1;
        for (int k = 0; k <= len; k++) aq[i].push_back(k);
    endtask
    always @(negedge clk) begin
        if (|a_bv) chk("arb_overlap", $countones(a_bv), 1);
        for (int i = 0; i < REQ_N; i++) begin
            if (a_bv[i]) begin
                chk("arb_beat_gnt", a_gnt[i], 1);
                a_beats[i]++;
                if (aq[i].size() == 0) chk("arb_unexpected", a_idx[i], -1);
                else chk("arb_idx", a_idx[i], aq[i].pop_front());
            end
            if (a_starve[i]) a_starves[i]++;
        end
        done_a += $countones(a_done);
    end
    logic [6:0] pat = 7'b1110011;
    int exp_idx [7] = '{0, 1, 1, 1, 2, 3, 4};
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int d0;
        for (int i = 0; i < REQ_N; i++) a_len[i] = '0;
        // reset together with an offered job: reset must win
        job_valid = 1'b1; job_len = 4'd3; a_jv = '1; g_jv = 1'b1;
        tick(); tick();
        rst = 1'b0; job_valid = 1'b0; a_jv = '0; g_jv = 1'b0;
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_ready", job_ready, 1);
        chk("rst_bv", beat_valid, 0);
        chk("rst_idx", beat_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_starve", starve, 0);
        chk("rst_arb_ready", a_rdy, 15);
        chk("rst_g_ready", g_rdy, 1);
        // zero-wait burst, len=3, gnt high throughout (also gnt in GAP/IDLE)
        tick();
        job_valid = 1'b1; job_len = 4'd3; gnt = 1'b1; push_job(3);
        tick();
        job_valid = 1'b0;
        @(negedge clk);
        chk("zw_req_t1", req, 1);
        chk("zw_bv_t1", beat_valid, 1);
        tick(); tick(); tick(); tick();
        @(negedge clk);
        chk("zw_done_t5", done, 1);
        chk("zw_req_t5", req, 0);
        chk("zw_ready_t5", job_ready, 0);
        chk("zw_gap_gnt_bv", beat_valid, 0);
        tick();
        @(negedge clk);
        chk("zw_ready_t6", job_ready, 1);
        chk("zw_done_t6", done, 0);
        chk("zw_idle_gnt_bv", beat_valid, 0);
        chk("zw_idle_req", req, 0);
        // starvation, len=0, gnt low for 12 cycles
        tick();
        chk("zw_sb_empty", q.size(), 0);
        gnt = 1'b0; job_valid = 1'b1; job_len = 4'd0; push_job(0);
        tick();
        job_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("st_starve", starve, int'(k == 9));
            chk("st_bv", beat_valid, 0);
            chk("st_req", req, 1);
            if (k < 12) tick();
        end
        tick();
        gnt = 1'b1;
        @(negedge clk);
        chk("st_beat", beat_valid, 1);
        tick();
        gnt = 1'b0;
        @(negedge clk);
        chk("st_done", done, 1);
        chk("st_req_low", req, 0);
        tick();
        @(negedge clk);
        chk("st_ready", job_ready, 1);
        // preemption, len=4, gnt 1,1,0,0,1,1,1
        tick();
        chk("st_sb_empty", q.size(), 0);
        job_valid = 1'b1; job_len = 4'd4; push_job(4);
        tick();
        job_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            gnt = pat[k];
            @(negedge clk);
            chk("pre_bv", beat_valid, int'(pat[k]));
            chk("pre_idx", beat_idx, exp_idx[k]);
            chk("pre_req", req, 1);
            tick();
        end
        d0 = done_cnt;
        gnt = 1'b0;
        @(negedge clk);
        chk("pre_done", done, 1);
        tick();
        chk("pre_done_once", done_cnt, d0 + 1);
        @(negedge clk);
        chk("pre_done_clear", done, 0);
        // reset in the cycle after beat 1 of a len=5 job
        tick();
        chk("pre_sb_empty", q.size(), 0);
        job_valid = 1'b1; job_len = 4'd5; gnt = 1'b1; push_job(2);
        tick();
        job_valid = 1'b0;
        tick(); tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_req", req, 0);
        chk("mr_ready", job_ready, 1);
        chk("mr_idx", beat_idx, 0);
        chk("mr_done", done, 0);
        chk("mr_bv", beat_valid, 0);
        tick();
        chk("mr_no_done", done_cnt, d0);
        chk("mr_sb_empty", q.size(), 0);
        job_valid = 1'b1; job_len = 4'd1; push_job(1);
        tick();
        job_valid = 1'b0;
        @(negedge clk);
        chk("mr_new_bv", beat_valid, 1);
        chk("mr_new_idx", beat_idx, 0);
        tick(); tick();
        @(negedge clk);
        chk("mr_new_done", done, 1);
        tick();
        @(negedge clk);
        chk("mr_new_ready", job_ready, 1);
        gnt = 1'b0;
        tick();
        chk("mr_sb_empty2", q.size(), 0);
        // GAP_CYC=0 instance, with gnt pulsed while idle
        g_gnt = 1'b1;
        @(negedge clk);
        chk("g0_idle_bv", g_bv, 0);
        chk("g0_idle_req", g_req, 0);
        chk("g0_idle_ready", g_rdy, 1);
        tick();
        g_jv = 1'b1; g_len = 4'd1;
        tick();
        g_jv = 1'b0;
        @(negedge clk);
        chk("g0_bv0", g_bv, 1);
        chk("g0_idx0", g_idx, 0);
        tick();
        @(negedge clk);
        chk("g0_idx1", g_idx, 1);
        tick();
        @(negedge clk);
        chk("g0_done", g_done, 1);
        chk("g0_gap_bv", g_bv, 0);
        chk("g0_gap_ready", g_rdy, 0);
        chk("g0_gap_req", g_req, 0);
        tick();
        @(negedge clk);
        chk("g0_ready", g_rdy, 1);
        chk("g0_done_clear", g_done, 0);
        chk("g0_starve", g_starve, 0);
        g_gnt = 1'b0;
        // four requesters on the arbiter: 1010, then 2 joins, then 0 preempts
        tick();
        arb_job(1, 2); arb_job(3, 1);
        a_jv = 4'b1010;
        chk("arb_accept_a", a_rdy & a_jv, 4'b1010);
        tick();
        a_jv = '0;
        tick(); tick();
        arb_job(2, 3);
        a_jv = 4'b0100;
        chk("arb_accept_b", a_rdy & a_jv, 4'b0100);
        tick();
        a_jv = '0;
        tick();
        arb_job(0, 0);
        a_jv = 4'b0001;
        chk("arb_accept_c", a_rdy & a_jv, 4'b0001);
        tick();
        a_jv = '0;
        for (int c = 0; c < 60 && done_a < 4; c++) tick();
        tick(); tick();
        chk("arb_done", done_a, 4);
        for (int i = 0; i < REQ_N; i++) begin
            chk("arb_beats", a_beats[i], exp_beats[i]);
            chk("arb_sb_empty", aq[i].size(), 0);
            chk("arb_starve", a_starves[i], int'(i == 3));
        end
        chk("arb_all_ready", a_rdy, 15);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
